// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler that shares one floating-point adder between NREQ requesters.
// Accept -> Go pulse -> bounded wait for Done -> result handshake back to the winner.
module fp_add_scheduler #(
  parameter int NREQ         = 4,
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int TIMEOUT      = 64,
  localparam int WIDTH       = 1 + EXPBITS + MANTISSABITS,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic [NREQ-1:0]       ReqValid,
  output logic [NREQ-1:0]       ReqReady,
  input  logic [NREQ*WIDTH-1:0] ReqA,
  input  logic [NREQ*WIDTH-1:0] ReqB,
  output logic [NREQ-1:0]       RspValid,
  input  logic [NREQ-1:0]       RspReady,
  output logic [WIDTH-1:0]      RspResult,
  output logic                  RspError,
  output logic                  AddGo,
  output logic [WIDTH-1:0]      AddA,
  output logic [WIDTH-1:0]      AddB,
  input  logic                  AddDone,
  input  logic [WIDTH-1:0]      AddResult,
  output logic                  Busy,
  output logic [IDW-1:0]        GrantId
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    grant_q;
  logic [CW-1:0]     count_q;
  logic [WIDTH-1:0]  add_a_q;
  logic [WIDTH-1:0]  add_b_q;
  logic [WIDTH-1:0]  rsp_result_q;
  logic              rsp_error_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              add_go_q;
  logic              busy_q;

  logic [IDW-1:0]    grant_d;
  logic              grant_vld_d;

  // Scan from the highest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    grant_d     = '0;
    grant_vld_d = 1'b0;
    idx         = 0;
    idx_w       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx   = (int'(ptr_q) + k) % NREQ;
      idx_w = IDW'(idx);
      if (ReqValid[idx_w]) begin
        grant_d     = idx_w;
        grant_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    ReqReady = '0;
    if (ResetN && state_q == IDLE && grant_vld_d) ReqReady[grant_d] = 1'b1;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      count_q      <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_valid_q  <= '0;
      add_go_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      add_go_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            add_a_q  <= ReqA[int'(grant_d)*WIDTH +: WIDTH];
            add_b_q  <= ReqB[int'(grant_d)*WIDTH +: WIDTH];
            grant_q  <= grant_d;
            add_go_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          count_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          count_q <= count_q + CW'(1);
          // Done has priority over a timeout landing in the same cycle.
          if (AddDone) begin
            rsp_result_q <= AddResult;
            rsp_error_q  <= 1'b0;
            rsp_valid_q  <= NREQ'(1) << grant_q;
            state_q      <= RESP;
          end else if (count_q == CW'(TIMEOUT - 1)) begin
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b1;
            rsp_valid_q  <= NREQ'(1) << grant_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (RspReady[grant_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            ptr_q       <= (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AddGo     = add_go_q;
  assign AddA      = add_a_q;
  assign AddB      = add_b_q;
  assign RspResult = rsp_result_q;
  assign RspError  = rsp_error_q;
  assign RspValid  = rsp_valid_q;
  assign Busy      = busy_q;
  assign GrantId   = grant_q;

endmodule
